// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller driving a two-port RAM: port A writes, port B reads with registered data.
// Optional FIFO_CTRL_LEVEL_EN adds the level/almost_full status ports and the AF_MARGIN parameter.
module ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 6
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  parameter int AF_MARGIN = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [DW-1:0] ram_data_a,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_we_a,
  output logic          ram_rd_a,
  output logic [DW-1:0] ram_data_b,
  output logic [AW-1:0] ram_addr_b,
  output logic          ram_we_b,
  output logic          ram_rd_b,
  input  logic [DW-1:0] ram_qb
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [AW+1:0] level,
  output logic          almost_full
`endif
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop, issue;

  always_comb begin
    in_ready    = (cnt_q != (AW+1)'(DEPTH));
    push        = in_valid & in_ready;
    pop         = out_valid_q & out_ready;
    issue       = (cnt_q != '0) & (~out_valid_q | out_ready);
    wr_ptr_d    = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    out_valid_d = issue ? 1'b1 : (pop ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The RAM's registered port-B output is the output stage; it holds while ram_rd_b is low.
  assign out_valid  = out_valid_q;
  assign out_data   = ram_qb;
  assign ram_data_a = in_data;
  assign ram_addr_a = wr_ptr_q;
  assign ram_we_a   = push;
  assign ram_rd_a   = 1'b0;
  assign ram_data_b = '0;
  assign ram_addr_b = rd_ptr_q;
  assign ram_we_b   = 1'b0;
  assign ram_rd_b   = issue;

`ifdef FIFO_CTRL_LEVEL_EN
  assign level       = (AW+2)'(cnt_q) + (AW+2)'(out_valid_q);
  assign almost_full = (level >= (AW+2)'(DEPTH + 1 - AF_MARGIN));
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and random bench for ram_fifo_ctrl with a behavioural 64x8 two-port RAM and a scoreboard queue.
// Define FIFO_CTRL_LEVEL_EN to also exercise level/almost_full.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_qb;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_we_a, ram_rd_a, ram_we_b, ram_rd_b;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [AW+1:0] level;
  logic          almost_full;
`endif

  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_rd_a(ram_rd_a),
    .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_rd_b(ram_rd_b),
    .ram_qb(ram_qb)
`ifdef FIFO_CTRL_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural two-port RAM: port A write, port B registered read that holds when not enabled.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_rd_b) ram_qb <= mem[ram_addr_b];
  end

  logic [DW-1:0] sb[$];
  int tests = 0;
  int fails = 0;
  int out_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: handshakes and outputs sampled at negedge, then past the next posedge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    if (ram_we_b !== 1'b0 || ram_rd_a !== 1'b0) chk("unused_port_strobes", {ram_we_b, ram_rd_a}, 0);
    if (rst_n && in_valid && in_ready) sb.push_back(in_data);
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) chk("sb_underflow", {24'h0, out_data}, 32'hDEAD);
      else begin
        e = sb.pop_front();
        chk("sb_data", {24'h0, out_data}, {24'h0, e});
      end
    end
    @(posedge clk);
    if (!rst_n) sb.delete();
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);

    // Test 1: single word latency
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    chk("t1_in_ready_n", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid_n1", out_valid, 0);
    chk("t1_in_ready_n1", in_ready, 1);
    tick();
    chk("t1_out_valid_n2", out_valid, 1);
    chk("t1_out_data_n2", out_data, 8'hA5);
    chk("t1_in_ready_n2", in_ready, 1);
    tick();
    chk("t1_out_valid_n3", out_valid, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Test 2: fill to full capacity under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (!in_ready) chk("t2_in_ready_early", in_ready, 1);
      tick();
    end
    in_data = 8'h41;
    chk("t2_in_ready_full", in_ready, 0);
    tick(); tick();
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_data", out_data, 8'h00);
    chk("t2_sb_size", sb.size(), 65);
    out_ready = 1'b1;
    chk("t2_full_pop_in_ready", in_ready, 0);
    tick();
    drain("t2_drain");

    // Test 3: sustained streaming across pointer wraps
    n0 = out_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 8'h80);
      tick();
    end
    chk("t3_throughput", out_cnt - n0, 198);
    drain("t3_drain");

    // Test 4: random valid/ready
    for (int i = 0; i < 5000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      tick();
    end
    drain("t4_drain");

    // Test 5: reset mid-stream discards contents
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_first_valid", out_valid, 1);
    chk("t5_first_data", out_data, 8'h3C);
    drain("t5_drain");

`ifdef FIFO_CTRL_LEVEL_EN
    // Test 6: level and almost_full
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_level_reset", level, 0);
    chk("t6_af_reset", almost_full, 0);
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_level_60", level, 60);
    chk("t6_af_60", almost_full, 0);
    in_valid = 1'b1; in_data = 8'd60;
    tick();
    in_valid = 1'b0;
    chk("t6_level_61", level, 61);
    chk("t6_af_61", almost_full, 1);
    drain("t6_drain");
    chk("t6_level_empty", level, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
